// File: rtl/uart_mmio_port.sv
// Memory-mapped 8N1 UART: data/status registers in front of TX and RX byte FIFOs.
// The status word is {rx_nonempty, tx_notfull}; reading the data register pops the RX FIFO.

module uart_mmio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       nonempty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          nonempty_q;
  logic          push_ok_s, pop_ok_s;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != CW'(0));
    push_ok_s = push_i && ((count_q != CW'(DEPTH)) || pop_ok_s);
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q     <= PW'(0);
      rptr_q     <= PW'(0);
      count_q    <= CW'(0);
      nonempty_q <= 1'b0;
    end else begin
      if (push_ok_s) wptr_q <= wptr_q + PW'(1);
      if (pop_ok_s)  rptr_q <= rptr_q + PW'(1);
      count_q    <= count_d;
      nonempty_q <= (count_d != CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o     = mem_q[rptr_q];
  assign full_o     = (count_q == CW'(DEPTH));
  assign nonempty_o = nonempty_q;
endmodule

module uart_mmio_port #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        rx_irq_o,
  output logic        txd,
  input  logic        rxd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BIT_END  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        tx_state_q, rx_state_q;
  logic [BW-1:0] tx_cnt_q, rx_cnt_q;
  logic [2:0]    tx_idx_q, rx_idx_q;
  logic [7:0]    tx_shift_q, rx_shift_q;
  logic          txd_q, rx_meta_q, rx_s_q;
  logic [31:0]   rdata_q, rdata_d;

  logic       tx_push_s, tx_pop_s, tx_full_s, tx_nonempty_s;
  logic       rx_push_s, rx_pop_s, rx_full_s, rx_nonempty_s;
  logic [7:0] tx_head_s, rx_head_s;

  assign tx_push_s = ce_i && we_i && !addr_i;
  assign rx_pop_s  = ce_i && !we_i && !addr_i;
  assign tx_pop_s  = tx_nonempty_s && ((tx_state_q == S_IDLE) ||
                     ((tx_state_q == S_STOP) && (tx_cnt_q == BIT_END)));
  assign rx_push_s = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END) && rx_s_q;

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push_s), .pop_i(tx_pop_s), .wdata_i(wdata_i),
    .head_o(tx_head_s), .full_o(tx_full_s), .nonempty_o(tx_nonempty_s)
  );

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push_s), .pop_i(rx_pop_s), .wdata_i(rx_shift_q),
    .head_o(rx_head_s), .full_o(rx_full_s), .nonempty_o(rx_nonempty_s)
  );

  // Register read mux; status is taken from pre-edge FIFO state.
  always_comb begin
    rdata_d = rdata_q;
    if (ce_i && !we_i) begin
      if (!addr_i) begin
        rdata_d = rx_nonempty_s ? {24'h000000, rx_head_s} : 32'h00000000;
      end else begin
        rdata_d = {30'h00000000, rx_nonempty_s, !tx_full_s};
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= 32'h00000000;
    else      rdata_q <= rdata_d;
  end

  // TX FSM; txd_q follows the state one cycle later, so every bit lasts exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= BW'(0);
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          txd_q    <= 1'b1;
          tx_cnt_q <= BW'(0);
          if (tx_nonempty_s) begin
            tx_shift_q <= tx_head_s;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          txd_q <= 1'b0;
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= BW'(0);
            tx_idx_q   <= 3'd0;
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + BW'(1);
          end
        end
        S_DATA: begin
          txd_q <= tx_shift_q[0];
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= BW'(0);
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_idx_q == 3'd7) tx_state_q <= S_STOP;
            else                  tx_idx_q   <= tx_idx_q + 3'd1;
          end else begin
            tx_cnt_q <= tx_cnt_q + BW'(1);
          end
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= BW'(0);
            if (tx_nonempty_s) begin
              tx_shift_q <= tx_head_s;
              tx_state_q <= S_START;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + BW'(1);
          end
        end
        default: begin
          txd_q      <= 1'b1;
          tx_state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RX synchronizer and FSM; the stop bit is judged at its centre, then the line is free again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= BW'(0);
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= BW'(0);
          if (!rx_s_q) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= BW'(0);
            rx_idx_q   <= 3'd0;
            rx_state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + BW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= BW'(0);
            rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + BW'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= BW'(0);
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + BW'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata_o  = rdata_q;
  assign rx_irq_o = rx_nonempty_s;
  assign txd      = txd_q;
endmodule

// File: tb/tb_uart_mmio_port.sv
// Directed bench for uart_mmio_port at DIV=16, FIFO_DEPTH=4; outputs sampled on the falling edge.

module tb_uart_mmio_port;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we, addr, rxd;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        irq, txd;
  logic [31:0] rd;
  logic        low_seen;
  int          n_cmp = 0;
  int          n_bad = 0;

  uart_mmio_port #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .rx_irq_o(irq), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge clk); ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk); ce = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); ce = 1'b0; d = rdata;
  endtask

  // Samples one TX frame at bit centres; pre = cycles to the start-bit centre. Returns on the next start cycle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int pre);
    logic [9:0] got;
    logic [9:0] exp;
    exp = {1'b1, b, 1'b0};
    repeat (pre) @(negedge clk);
    got[0] = txd;
    for (int j = 1; j < 10; j++) begin
      repeat (16) @(negedge clk);
      got[j] = txd;
    end
    repeat (8) @(negedge clk);
    chk(tag, {22'h0, got}, {22'h0, exp});
  endtask

  // Drives one 8N1 frame on rxd starting now; optionally checks irq is still low early in the stop bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_b, input logic chk_irq);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rxd = f[j];
      if (j == 9 && chk_irq) begin
        repeat (6) @(negedge clk);
        chk("rx_irq_before_stop", {31'h0, irq}, 32'h0);
        repeat (10) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 1'b0; wdata = 8'h00; rxd = 1'b1;

    // 1: reset
    repeat (2) @(negedge clk);
    chk("rst_txd", {31'h0, txd}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b1;
    bus_read(1'b1, rd);
    chk("rst_status", rd, 32'h1);

    // 2: single TX byte, start bit two cycles after the write edge
    bus_write(1'b0, 8'h55);
    chk("tx_lat0", {31'h0, txd}, 32'h1);
    @(negedge clk);
    chk("tx_lat1", {31'h0, txd}, 32'h1);
    @(negedge clk);
    chk("tx_start_edge", {31'h0, txd}, 32'h0);
    expect_frame("tx_55", 8'h55, 8);
    chk("tx_idle_after", {31'h0, txd}, 32'h1);
    repeat (20) @(negedge clk);

    // 3: six back-to-back writes, sixth dropped
    ce = 1'b1; we = 1'b1; addr = 1'b0; wdata = 8'h01;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk); wdata = i[7:0];
    end
    @(negedge clk); we = 1'b0; addr = 1'b1;
    @(negedge clk);
    chk("tx_full_status", rdata, 32'h0);
    we = 1'b1; addr = 1'b0; wdata = 8'h06;
    @(negedge clk); ce = 1'b0; we = 1'b0;
    expect_frame("tx3_f1", 8'h01, 4);
    expect_frame("tx3_f2", 8'h02, 8);
    expect_frame("tx3_f3", 8'h03, 8);
    expect_frame("tx3_f4", 8'h04, 8);
    expect_frame("tx3_f5", 8'h05, 8);
    repeat (8) @(negedge clk);
    chk("tx3_no_sixth", {31'h0, txd}, 32'h1);
    bus_read(1'b1, rd);
    chk("tx3_status_end", rd, 32'h1);

    // 4: receive 0xA3
    send_rx(8'hA3, 1'b1, 1'b1);
    chk("rx_irq_set", {31'h0, irq}, 32'h1);
    bus_read(1'b1, rd);
    chk("rx_status", rd, 32'h3);
    bus_read(1'b0, rd);
    chk("rx_data_a3", rd, 32'hA3);
    chk("rx_irq_clear", {31'h0, irq}, 32'h0);

    // 5: glitch, framing error, overflow
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("rx_glitch_irq", {31'h0, irq}, 32'h0);
    send_rx(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("rx_frame_err_irq", {31'h0, irq}, 32'h0);
    bus_read(1'b1, rd);
    chk("rx_err_status", rd, 32'h1);
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    send_rx(8'h33, 1'b1, 1'b0);
    send_rx(8'h44, 1'b1, 1'b0);
    send_rx(8'h55, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    bus_read(1'b1, rd);
    chk("rx_ovf_status", rd, 32'h3);
    bus_read(1'b0, rd); chk("rx_ovf_0", rd, 32'h11);
    bus_read(1'b0, rd); chk("rx_ovf_1", rd, 32'h22);
    bus_read(1'b0, rd); chk("rx_ovf_2", rd, 32'h33);
    bus_read(1'b0, rd); chk("rx_ovf_3", rd, 32'h44);
    bus_read(1'b0, rd); chk("rx_empty_read", rd, 32'h0);
    chk("rx_ovf_irq", {31'h0, irq}, 32'h0);

    // 6: reset during bit 3 of 0xFF with a second byte queued
    bus_write(1'b0, 8'hFF);
    bus_write(1'b0, 8'hFF);
    chk("tx6_start", {31'h0, txd}, 32'h0);
    repeat (68) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("tx6_rst_txd", {31'h0, txd}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus_read(1'b1, rd);
    chk("tx6_status", rd, 32'h1);
    low_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    chk("tx6_no_frame", {31'h0, low_seen}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
